// File: rtl/mux_pkg.sv
// Shared constants, select type and pointer helper for the 8-to-1 stream merger.
package mux_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef logic [SEL_W-1:0] sel_t;

  // Relies on the 3-bit sel_t wrapping naturally, so 7 advances to 0.
  function automatic sel_t next_ptr(sel_t p);
    return p + sel_t'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter_8.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
module rr_arbiter_8
  import mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  sel_t              ptr,
  output logic [NUM_CH-1:0] gnt_onehot,
  output sel_t              gnt_idx,
  output logic              any
);

  // Scanning from the far end backwards leaves the closest requester to ptr as the winner.
  always_comb begin
    gnt_idx    = '0;
    any        = 1'b0;
    gnt_onehot = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req[sel_t'(ptr + sel_t'(k))]) begin
        gnt_idx = sel_t'(ptr + sel_t'(k));
        any     = 1'b1;
      end
    end
    gnt_onehot[gnt_idx] = any;
  end

endmodule

// File: rtl/mux_8x1_stream.sv
// Merges 8 valid/ready streams into one registered, source-tagged output stream.
// Define MUX_8X1_PKT_LOCK_EN to hold the grant on one channel until its in_last beat.
module mux_8x1_stream
  import mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output sel_t                    out_sel,
  input  logic                    out_ready
`ifdef MUX_8X1_PKT_LOCK_EN
  ,
  input  logic [NUM_CH-1:0]       in_last,
  output logic                    out_last
`endif
);

  sel_t              ptr;
  sel_t              gnt_idx;
  sel_t              g;
  logic [NUM_CH-1:0] gnt_onehot;
  logic              any;
  logic              load;
  logic              fire;

  rr_arbiter_8 u_arb (
    .req        (in_valid),
    .ptr        (ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  assign load = !out_valid || out_ready;

`ifdef MUX_8X1_PKT_LOCK_EN
  logic locked;
  sel_t lock_ch;

  assign g = locked ? lock_ch : gnt_idx;
`else
  assign g = gnt_idx;
`endif

  // Gated by rst_n so no producer sees a ready while the block is held in reset.
  always_comb begin
    in_ready = '0;
    if (rst_n && load) begin
`ifdef MUX_8X1_PKT_LOCK_EN
      if (locked) in_ready[lock_ch] = 1'b1;
      else        in_ready = gnt_onehot;
`else
      in_ready = gnt_onehot;
`endif
    end
  end

  assign fire = |(in_valid & in_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
`ifdef MUX_8X1_PKT_LOCK_EN
      out_last  <= 1'b0;
      locked    <= 1'b0;
      lock_ch   <= '0;
`endif
    end else if (fire) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(g)*WIDTH +: WIDTH];
      out_sel   <= g;
`ifdef MUX_8X1_PKT_LOCK_EN
      out_last  <= in_last[g];
      if (in_last[g]) begin
        locked <= 1'b0;
        ptr    <= next_ptr(g);
      end else begin
        locked  <= 1'b1;
        lock_ch <= g;
      end
`else
      ptr       <= next_ptr(g);
`endif
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_8x1_stream.sv
// Scoreboard bench for mux_8x1_stream; covers the MUX_8X1_PKT_LOCK_EN build when defined.
module tb_mux_8x1_stream;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_valid;
  logic [63:0] in_data;
  logic [7:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [2:0]  out_sel;
  logic        out_ready;
`ifdef MUX_8X1_PKT_LOCK_EN
  logic [7:0]  in_last;
  logic        out_last;
`endif

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  beat_t mb;

  mux_8x1_stream #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
`ifdef MUX_8X1_PKT_LOCK_EN
    ,
    .in_last   (in_last),
    .out_last  (out_last)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [2:0] s, input logic [7:0] d, input logic l);
    beat_t b;
    b.sel  = s;
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic set_ch(input int i, input logic [7:0] d);
    in_data[i*8 +: 8] = d;
  endtask

  task automatic apply_stimulus(input logic [7:0] v);
    @(posedge clk);
    #1 in_valid = v;
  endtask

  // Retires one expected beat for every handshake the consumer side sees.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_beat: got sel=%0d data=%02h, required no beat", out_sel, out_data);
      end else begin
        mb = exp_q.pop_front();
        check_output("beat_sel", 32'(out_sel), 32'(mb.sel));
        check_output("beat_data", 32'(out_data), 32'(mb.data));
`ifdef MUX_8X1_PKT_LOCK_EN
        check_output("beat_last", 32'(out_last), 32'(mb.last));
`endif
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    in_data   = '0;
`ifdef MUX_8X1_PKT_LOCK_EN
    in_last   = '0;
`endif
    for (int i = 0; i < 8; i++) set_ch(i, 8'hA0 + 8'(i));

    repeat (2) @(posedge clk);
    #1;
    check_output("reset_out_valid", 32'(out_valid), 0);
    check_output("reset_in_ready", 32'(in_ready), 0);
    check_output("reset_out_sel", 32'(out_sel), 0);
    check_output("reset_out_data", 32'(out_data), 0);
`ifdef MUX_8X1_PKT_LOCK_EN
    check_output("reset_out_last", 32'(out_last), 0);
`endif

    // Round robin across all lanes, wrapping back to channel 0.
    rst_n = 1'b1;
    #1 check_output("first_grant", 32'(in_ready), 32'h01);
    for (int i = 0; i < 8; i++) push_exp(3'(i), 8'hA0 + 8'(i), 1'b0);
    push_exp(3'd0, 8'hA0, 1'b0);
    repeat (9) @(posedge clk);
    #1 in_valid = 8'h00;
    repeat (2) @(posedge clk);
    #1 check_output("rr_drained", 32'(out_valid), 0);

    // Move ptr to 7 via ch6, then ch7/ch1 alternate across the wrap.
    push_exp(3'd6, 8'hA6, 1'b0);
    push_exp(3'd7, 8'hA7, 1'b0);
    push_exp(3'd1, 8'hA1, 1'b0);
    push_exp(3'd7, 8'hA7, 1'b0);
    apply_stimulus(8'h40);
    apply_stimulus(8'h82);
    repeat (2) @(posedge clk);
    apply_stimulus(8'h00);
    repeat (2) @(posedge clk);

    // Stall with 0x5C held while ch3 keeps a second beat pending.
    #1;
    out_ready = 1'b0;
    set_ch(3, 8'h5C);
    push_exp(3'd3, 8'h5C, 1'b0);
    push_exp(3'd3, 8'h5D, 1'b0);
    apply_stimulus(8'h08);
    @(posedge clk);
    #1 set_ch(3, 8'h5D);
    for (int i = 0; i < 5; i++) begin
      check_output("stall_valid", 32'(out_valid), 1);
      check_output("stall_sel", 32'(out_sel), 3);
      check_output("stall_data", 32'(out_data), 32'h5C);
      check_output("stall_in_ready", 32'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1 check_output("stall_release_ready", 32'(in_ready), 32'h08);
    apply_stimulus(8'h00);
    check_output("stall_next_data", 32'(out_data), 32'h5D);

    // Single beat on ch4 followed by an idle input side.
    @(posedge clk);
    #1;
    set_ch(4, 8'h4E);
    push_exp(3'd4, 8'h4E, 1'b0);
    in_valid = 8'h10;
    apply_stimulus(8'h00);
    check_output("drain_valid_hi", 32'(out_valid), 1);
    check_output("drain_sel_hi", 32'(out_sel), 4);
    @(posedge clk);
    #1;
    check_output("drain_valid_lo", 32'(out_valid), 0);
    check_output("drain_sel_hold", 32'(out_sel), 4);
    check_output("drain_data_hold", 32'(out_data), 32'h4E);

`ifdef MUX_8X1_PKT_LOCK_EN
    // ptr now sits at 5; ch2 starts a packet before ch5 joins and must wait.
    set_ch(2, 8'h21);
    set_ch(5, 8'h55);
    in_last = 8'h20;
    push_exp(3'd2, 8'h21, 1'b0);
    push_exp(3'd2, 8'h22, 1'b0);
    push_exp(3'd2, 8'h23, 1'b1);
    push_exp(3'd5, 8'h55, 1'b1);
    in_valid = 8'h04;
    apply_stimulus(8'h24);
    set_ch(2, 8'h22);
    check_output("lock_in_ready", 32'(in_ready), 32'h04);
    @(posedge clk);
    #1;
    set_ch(2, 8'h23);
    in_last = 8'h24;
    apply_stimulus(8'h20);
    @(posedge clk);
    #1 in_valid = 8'h00;
    in_last = 8'h00;
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check_output("queue_empty", 32'(exp_q.size()), 0);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
